fram_mem_arbiter: RTL and testbench
===================================

Name: fram_mem_arbiter

Overview:
- Shares the single FRAM-backed memory port between the core's instruction-fetch requester and data load/store requester.
- Selects one requester and issues one transaction downstream, holding its payload stable until the memory port reports completion.
- Returns read data plus a one-cycle done pulse to the owning requester.
- Sits between the core and the FRAM byte-sequencing memory controller. Also provides round-robin fairness and a stuck-transaction watchdog.

Parameters:
- TIMEOUT_CYCLES, 4096, cycles in a downstream wait state before the sticky timeout flag sets; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  fetch request; held with if_addr until if_done
- if_addr  in  32  fetch address; always a word read
- if_done  out  1  one-cycle pulse, fetch complete
- if_rdata  out  32  fetch data; valid while if_done=1, holds afterwards
- d_valid  in  1  data request; held with payload until d_done
- d_addr  in  32  data address
- d_write_en  in  1  1=store, 0=load
- d_size  in  2  00=byte, 01=halfword, 10=word
- d_sign_ext  in  1  sign-extend load
- d_wdata  in  32  store data
- d_done  out  1  one-cycle pulse, data transaction complete
- d_rdata  out  32  load data; valid while d_done=1, holds afterwards
- m_req_valid  out  1  downstream request
- m_req_ready  in  1  downstream ready; high when idle, low while busy
- m_addr, m_write_en, m_size, m_sign_ext, m_wdata  out  32/1/2/1/32  downstream payload
- m_rdata  in  32  downstream read data
- busy  out  1  arbiter is not in IDLE
- timeout  out  1  sticky watchdog flag

Behaviour:
- Reset: all outputs 0, including m_* payload, rdata outputs and timeout. State IDLE, last_grant=DATA (fetch wins the first contention).
- States: IDLE -> ISSUE -> WAIT_LOW -> WAIT_HIGH -> RESP -> IDLE.
- IDLE, arbitration:
  - Only one valid: grant it.
  - Both valid: grant the requester not equal to last_grant.
  - On grant: latch owner and payload into the m_* registers, set last_grant=owner, go to ISSUE.
  - Fetch payload is forced to write_en=0, size=10, sign_ext=0, wdata=0.
- ISSUE: m_req_valid=1 while m_req_ready=1. Stay in ISSUE while m_req_ready=0. After the accept edge, m_req_valid=0 and go to WAIT_LOW.
  - m_req_valid is high for exactly one accepted cycle, never two.
- WAIT_LOW: wait for m_req_ready=0, then go to WAIT_HIGH.
- WAIT_HIGH: wait for m_req_ready=1. On that cycle capture m_rdata into the owner's rdata register and go to RESP.
- RESP: owner's done=1 for exactly this cycle, then go to IDLE.
  - A requester may deassert or change payload the cycle after done.
  - Re-arbitration happens in the following IDLE cycle.
- Payload stability: m_* payload is unchanged from ISSUE through RESP. The downstream block reads size, sign_ext and write_en during its completion cycle.
- Store completion: d_done pulses as for loads. d_rdata is still updated with m_rdata (don't-care value).
- Minimum turnaround: request seen in IDLE -> done is ISSUE + WAIT_LOW + WAIT_HIGH (>=1 each) + RESP, i.e. ≥4 cycles after grant.
- No back-to-back IDLE skip. Each transaction passes through IDLE, one cycle minimum gap.
- Requester dropping valid before done: ignored. The transaction completes and done still pulses.
- Watchdog: a counter runs in WAIT_LOW/WAIT_HIGH and clears on state entry.
  - Reaching TIMEOUT_CYCLES sets timeout=1 (sticky until reset). The FSM keeps waiting; no abort.
- busy = (state != IDLE).
- Reset mid-transaction: asynchronous return to IDLE, all outputs 0, no done emitted.

Test Plan:
- Fetch only:
  - Stimulus: if_addr=0x100; downstream model returns m_rdata=0x00C0FFEE 6 cycles after accept.
  - Required response: single m_req_valid cycle with m_size=10, m_write_en=0; if_done pulses once with if_rdata=0x00C0FFEE.
- Data signed-byte load:
  - Stimulus: d_addr=0x20, d_size=00, d_sign_ext=1.
  - Required response: m_* payload matches request and is stable through completion; d_rdata=m_rdata=0xFFFFFF80; if_done stays 0.
- Simultaneous requests after reset:
  - Stimulus: if_valid and d_valid asserted together, both held high.
  - Required response: grants go fetch, data, fetch, data; each done is a single pulse.
- Store:
  - Stimulus: d_write_en=1, d_size=10, d_wdata=0xA5A5_1234.
  - Required response: m_wdata=0xA5A51234 and m_write_en=1 from ISSUE to RESP; d_done pulses; no if_done.
- Watchdog:
  - Stimulus: TIMEOUT_CYCLES=16; downstream holds m_req_ready=0 indefinitely.
  - Required response: timeout rises 16 cycles into the wait and stays high. When ready returns, d_done still pulses.
- Reset mid-WAIT_HIGH:
  - Stimulus: assert rst_n=0.
  - Required response: busy=0, m_req_valid=0, no done pulse. A post-reset fetch completes normally.

Source files
------------

// File: rtl/fram_mem_arbiter_if.sv
// fram_mem_arbiter_if: downstream FRAM memory port between the arbiter and the byte-sequencing controller.
// master = arbiter side (issues request and payload), slave = memory controller side (ready and read data).
// m_req_ready is high while the controller is idle and low while it works; m_rdata is valid when ready returns.
interface fram_mem_arbiter_if;
  logic        m_req_valid;
  logic        m_req_ready;
  logic [31:0] m_addr;
  logic        m_write_en;
  logic [1:0]  m_size;
  logic        m_sign_ext;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  modport master (
    output m_req_valid, m_addr, m_write_en, m_size, m_sign_ext, m_wdata,
    input  m_req_ready, m_rdata
  );

  modport slave (
    input  m_req_valid, m_addr, m_write_en, m_size, m_sign_ext, m_wdata,
    output m_req_ready, m_rdata
  );
endinterface

// File: rtl/fram_mem_arbiter.sv
// fram_mem_arbiter: shares one FRAM memory port between instruction fetch and data load/store, round-robin.
// Latency: grant to done is >= 4 cycles (ISSUE, WAIT_LOW, WAIT_HIGH, RESP); every transaction returns through IDLE.
// Backpressure: requesters hold valid+payload until done; the downstream port paces us with m_req_ready.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   if_valid, if_addr              fetch request (always a word read)
//   if_done, if_rdata              fetch completion pulse and read data (holds after the pulse)
//   d_valid, d_addr, d_write_en,
//   d_size, d_sign_ext, d_wdata    data request
//   d_done, d_rdata                data completion pulse and load data (holds after the pulse)
//   mem                            downstream memory port, master side
//   busy                           arbiter is not idle
//   timeout                        sticky watchdog flag (TIMEOUT_CYCLES = 0 disables it)
module fram_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       if_valid,
  input  logic [31:0]                if_addr,
  output logic                       if_done,
  output logic [31:0]                if_rdata,
  input  logic                       d_valid,
  input  logic [31:0]                d_addr,
  input  logic                       d_write_en,
  input  logic [1:0]                 d_size,
  input  logic                       d_sign_ext,
  input  logic [31:0]                d_wdata,
  output logic                       d_done,
  output logic [31:0]                d_rdata,
  fram_mem_arbiter_if.master         mem,
  output logic                       busy,
  output logic                       timeout
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_HIGH = 3'd3,
    RESP      = 3'd4
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] WD_LAST = WD_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  state_t      state, state_nxt;
  // The last grant doubles as the owner of the transaction in flight:
  // it is written on every grant and never changes until the next one.
  owner_t      last_grant;
  owner_t      grant;
  logic        grant_vld;
  logic        capture;
  logic        req_valid_c;
  logic        if_done_c;
  logic        d_done_c;
  logic        in_wait;

  logic [31:0] addr_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        sext_q;
  logic [31:0] wdata_q;
  logic [31:0] if_rdata_q;
  logic [31:0] d_rdata_q;
  logic [31:0] wd_cnt;
  logic        timeout_q;

  // Round-robin: on contention the requester that did not win last time gets the port.
  always_comb begin
    grant     = last_grant;
    grant_vld = 1'b0;
    if (if_valid && d_valid) begin
      grant_vld = 1'b1;
      grant     = (last_grant == OWN_DATA) ? OWN_FETCH : OWN_DATA;
    end else if (if_valid) begin
      grant_vld = 1'b1;
      grant     = OWN_FETCH;
    end else if (d_valid) begin
      grant_vld = 1'b1;
      grant     = OWN_DATA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    capture     = 1'b0;
    req_valid_c = 1'b0;
    if_done_c   = 1'b0;
    d_done_c    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld) state_nxt = ISSUE;
      end
      ISSUE: begin
        // Request is only shown when the controller can take it, so the
        // single cycle it is high is also the accept cycle.
        req_valid_c = mem.m_req_ready;
        if (mem.m_req_ready) state_nxt = WAIT_LOW;
      end
      WAIT_LOW: begin
        // Controller must first acknowledge by dropping ready, otherwise the
        // still-high idle ready would be mistaken for completion.
        if (!mem.m_req_ready) state_nxt = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (mem.m_req_ready) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if_done_c = (last_grant == OWN_FETCH);
        d_done_c  = (last_grant == OWN_DATA);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Payload registers are only loaded on a grant, which keeps m_* stable
  // from ISSUE through RESP regardless of what the requesters do.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= OWN_DATA;
      addr_q     <= 32'd0;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      sext_q     <= 1'b0;
      wdata_q    <= 32'd0;
      if_rdata_q <= 32'd0;
      d_rdata_q  <= 32'd0;
    end else begin
      if (state == IDLE && grant_vld) begin
        last_grant <= grant;
        if (grant == OWN_FETCH) begin
          addr_q  <= if_addr;
          we_q    <= 1'b0;
          size_q  <= 2'b10;
          sext_q  <= 1'b0;
          wdata_q <= 32'd0;
        end else begin
          addr_q  <= d_addr;
          we_q    <= d_write_en;
          size_q  <= d_size;
          sext_q  <= d_sign_ext;
          wdata_q <= d_wdata;
        end
      end
      if (capture) begin
        if (last_grant == OWN_FETCH) if_rdata_q <= mem.m_rdata;
        else                         d_rdata_q  <= mem.m_rdata;
      end
    end
  end

  // Watchdog: counts cycles spent in the current wait state; any state change
  // restarts it. Only flags the hang, the transaction is never aborted.
  assign in_wait = (state == WAIT_LOW) || (state == WAIT_HIGH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt    <= 32'd0;
      timeout_q <= 1'b0;
    end else begin
      if (!in_wait || state_nxt != state) wd_cnt <= 32'd0;
      else if (wd_cnt != 32'hFFFF_FFFF)   wd_cnt <= wd_cnt + 32'd1;
      if (WD_EN && in_wait && wd_cnt == WD_LAST) timeout_q <= 1'b1;
    end
  end

  assign mem.m_req_valid = req_valid_c;
  assign mem.m_addr      = addr_q;
  assign mem.m_write_en  = we_q;
  assign mem.m_size      = size_q;
  assign mem.m_sign_ext  = sext_q;
  assign mem.m_wdata     = wdata_q;

  assign if_done  = if_done_c;
  assign d_done   = d_done_c;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign busy     = (state != IDLE);
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_fram_mem_arbiter.sv
// tb_fram_mem_arbiter: drives fetch/data requesters and a behavioural FRAM controller into fram_mem_arbiter.
// Inputs change on the falling edge; DUT outputs are sampled on the falling edge (or #1 after an async reset).
// Controller model: ready drops the edge after accept, stays low mem_lat cycles, returns with read data.
module tb_fram_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid, if_done;
  logic [31:0] if_addr, if_rdata;
  logic        d_valid, d_write_en, d_sign_ext, d_done;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        busy, timeout;

  fram_mem_arbiter_if mif();

  fram_mem_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_valid(d_valid), .d_addr(d_addr), .d_write_en(d_write_en), .d_size(d_size),
    .d_sign_ext(d_sign_ext), .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata),
    .mem(mif), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural FRAM controller ----------------
  int          mem_lat  = 1;
  logic        mem_hang = 1'b0;
  logic [31:0] mem_data = 32'd0;
  logic [31:0] mem_ret  = 32'd0;
  int          mem_cnt  = 0;
  logic        mem_acc;

  initial begin
    mif.m_req_ready = 1'b1;
    mif.m_rdata     = 32'd0;
    forever begin
      @(negedge clk);
      mem_acc = mif.m_req_valid & mif.m_req_ready;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        mif.m_req_ready = 1'b1;
        mem_cnt = 0;
      end else if (mem_acc) begin
        mif.m_req_ready = 1'b0;
        mif.m_rdata     = ~mem_data;   // garbage while busy
        mem_cnt         = mem_lat;
      end else if (mem_cnt > 0 && !mem_hang) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          mif.m_rdata     = mem_data;
          mem_ret         = mem_data;
          mif.m_req_ready = 1'b1;
        end
      end
    end
  end

  // ---------------- table of single transactions ----------------
  typedef struct {
    logic        is_fetch;
    logic [31:0] addr;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        exp_we;
    logic [1:0]  exp_size;
    logic        exp_sext;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[5];

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; if_valid = 1'b0; d_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int acc_t, done_t, mv, own_d, oth_d;
    logic stable;
    logic [67:0] snap, cur, exp_pl;
    logic [31:0] got;
    mem_lat = v.lat; mem_data = v.rdata;
    @(negedge clk);
    d_write_en = v.we; d_size = v.size; d_sign_ext = v.sext; d_wdata = v.wdata;
    if (v.is_fetch) begin if_addr = v.addr; d_addr = ~v.addr; if_valid = 1'b1; end
    else            begin d_addr = v.addr; d_valid = 1'b1; end
    acc_t = -1; done_t = -1; mv = 0; own_d = 0; oth_d = 0; stable = 1'b1; snap = '0; got = '0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      cur = {mif.m_addr, mif.m_write_en, mif.m_size, mif.m_sign_ext, mif.m_wdata};
      if (mif.m_req_valid) begin
        mv++;
        if (acc_t < 0) begin acc_t = t; snap = cur; end
      end
      if (acc_t >= 0 && done_t < 0 && cur !== snap) stable = 1'b0;
      if (v.is_fetch ? if_done : d_done) begin
        own_d++;
        if (done_t < 0) begin
          done_t = t;
          got = v.is_fetch ? if_rdata : d_rdata;
          if_valid = 1'b0; d_valid = 1'b0;
        end
      end
      if (v.is_fetch ? d_done : if_done) oth_d++;
    end
    if_valid = 1'b0; d_valid = 1'b0;
    exp_pl = {v.addr, v.exp_we, v.exp_size, v.exp_sext, v.exp_wdata};
    check({tag, " payload"}, snap, exp_pl);
    check({tag, " req_valid cycles"}, mv, 1);
    check({tag, " done pulses"}, own_d, 1);
    check({tag, " other done"}, oth_d, 0);
    check({tag, " rdata"}, got, v.rdata);
    check({tag, " accept-to-done"}, done_t - acc_t, v.lat + 2);
    check({tag, " payload stable"}, stable, 1'b1);
    check({tag, " rdata holds"}, v.is_fetch ? if_rdata : d_rdata, v.rdata);
    check({tag, " idle after"}, busy, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  int          order[4];
  int          grants, dones, dn, acc, rise, m_last, cur_own, ndone;
  logic        prev_done, pulse_ok, prev_f, prev_d, in_txn, stable;
  logic [67:0] pl, cur_pl, exp_pl;

  initial begin
    //          fetch addr           we    size   sext  wdata           lat rdata          exp_we exp_sz exp_sx exp_wdata
    vecs[0] = '{1'b1, 32'h0000_0100, 1'b1, 2'b01, 1'b1, 32'hFFFF_0000, 6, 32'h00C0_FFEE, 1'b0, 2'b10, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_0020, 1'b0, 2'b00, 1'b1, 32'h1234_5678, 3, 32'hFFFF_FF80, 1'b0, 2'b00, 1'b1, 32'h1234_5678};
    vecs[2] = '{1'b0, 32'h0000_0044, 1'b1, 2'b10, 1'b0, 32'hA5A5_1234, 2, 32'h0000_DEAD, 1'b1, 2'b10, 1'b0, 32'hA5A5_1234};
    vecs[3] = '{1'b0, 32'h0000_1002, 1'b0, 2'b01, 1'b0, 32'h0,         1, 32'h0000_BEEF, 1'b0, 2'b01, 1'b0, 32'h0};
    vecs[4] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 2'b00, 1'b0, 32'h0,         1, 32'h8765_4321, 1'b0, 2'b10, 1'b0, 32'h0};

    rst_n = 1'b0; if_valid = 1'b0; if_addr = '0; d_valid = 1'b0; d_addr = '0;
    d_write_en = 1'b0; d_size = 2'b00; d_sign_ext = 1'b0; d_wdata = '0;
    repeat (2) @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset timeout", timeout, 1'b0);
    check("reset dones", {if_done, d_done}, 2'b00);
    check("reset m_req_valid", mif.m_req_valid, 1'b0);
    check("reset payload", {mif.m_addr, mif.m_write_en, mif.m_size, mif.m_sign_ext, mif.m_wdata}, 68'h0);
    check("reset rdata", {if_rdata, d_rdata}, 64'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Simultaneous requests right after reset: fetch must win first, then alternate.
    do_reset();
    mem_lat = 2; mem_data = 32'h0000_0042;
    @(negedge clk);
    if_addr = 32'h200; d_addr = 32'h300; d_write_en = 1'b0; d_size = 2'b10; d_sign_ext = 1'b0;
    if_valid = 1'b1; d_valid = 1'b1;
    grants = 0; dones = 0; prev_done = 1'b0; pulse_ok = 1'b1;
    for (int i = 0; i < 4; i++) order[i] = -1;
    for (int t = 0; t < 100 && dones < 4; t++) begin
      @(negedge clk);
      if (mif.m_req_valid && grants < 4) begin order[grants] = (mif.m_addr == 32'h300) ? 1 : 0; grants++; end
      if (if_done || d_done) begin
        dones++;
        if (prev_done || (if_done && d_done)) pulse_ok = 1'b0;
      end
      prev_done = if_done | d_done;
    end
    if_valid = 1'b0; d_valid = 1'b0;
    for (int i = 0; i < 4; i++) check($sformatf("rr grant %0d (1=data)", i), order[i], i % 2);
    check("rr done count", dones, 4);
    check("rr single pulses", pulse_ok, 1'b1);

    // Requester drops valid right after accept: transaction still completes.
    mem_lat = 4; mem_data = 32'h5A5A_0001;
    @(negedge clk);
    d_addr = 32'h40; d_write_en = 1'b0; d_size = 2'b10; d_valid = 1'b1;
    acc = -1; dn = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (mif.m_req_valid && acc < 0) begin acc = t; d_valid = 1'b0; end
      if (d_done) dn++;
    end
    d_valid = 1'b0;
    check("early drop accepted", acc >= 0, 1'b1);
    check("early drop done", dn, 1);
    check("early drop rdata", d_rdata, 32'h5A5A_0001);

    // Randomized traffic against the arbitration / scoreboard model.
    do_reset();
    prev_f = 1'b0; prev_d = 1'b0; in_txn = 1'b0; stable = 1'b1; m_last = 1; cur_own = 0; ndone = 0; cur_pl = '0;
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      mem_lat  = $urandom_range(1, 8);
      mem_data = $urandom;
      pl = {mif.m_addr, mif.m_write_en, mif.m_size, mif.m_sign_ext, mif.m_wdata};
      if (mif.m_req_valid) begin
        check("rand grant had a requester", prev_f | prev_d, 1'b1);
        cur_own = (prev_f && prev_d) ? ((m_last == 1) ? 0 : 1) : (prev_f ? 0 : 1);
        exp_pl  = (cur_own == 0) ? {if_addr, 1'b0, 2'b10, 1'b0, 32'h0}
                                 : {d_addr, d_write_en, d_size, d_sign_ext, d_wdata};
        check("rand payload", pl, exp_pl);
        m_last = cur_own; in_txn = 1'b1; cur_pl = pl; stable = 1'b1;
      end else if (in_txn && pl !== cur_pl) begin
        stable = 1'b0;
      end
      if (if_done || d_done) begin
        check("rand done owner", {if_done, d_done}, in_txn ? ((cur_own == 0) ? 2'b10 : 2'b01) : 2'b00);
        check("rand rdata", (cur_own == 0) ? if_rdata : d_rdata, mem_ret);
        check("rand stable", stable, 1'b1);
        in_txn = 1'b0; ndone++;
        if (if_done) if_valid = 1'b0;
        if (d_done)  d_valid  = 1'b0;
      end
      if (ndone < 40) begin
        if (!if_valid && !if_done && $urandom_range(0, 3) == 0) begin
          if_addr = $urandom & 32'hFFFF_FFFC; if_valid = 1'b1;
        end
        if (!d_valid && !d_done && $urandom_range(0, 3) == 0) begin
          d_addr = $urandom; d_write_en = 1'($urandom_range(0, 1)); d_size = 2'($urandom_range(0, 2));
          d_sign_ext = 1'($urandom_range(0, 1)); d_wdata = $urandom; d_valid = 1'b1;
        end
      end else if (!if_valid && !d_valid && !in_txn) begin
        break;
      end
      prev_f = if_valid; prev_d = d_valid;
    end
    if_valid = 1'b0; d_valid = 1'b0;
    check("rand completions", ndone >= 40, 1'b1);
    check("rand no timeout", timeout, 1'b0);

    // Watchdog: controller accepts then never returns ready.
    mem_lat = 3; mem_data = 32'h0BAD_F00D; mem_hang = 1'b1;
    @(negedge clk);
    d_addr = 32'h80; d_write_en = 1'b0; d_size = 2'b10; d_sign_ext = 1'b0; d_valid = 1'b1;
    acc = -1; rise = -1;
    for (int t = 0; t < 60 && rise < 0; t++) begin
      @(negedge clk);
      if (mif.m_req_valid && acc < 0) acc = t;
      if (timeout && rise < 0) rise = t;
    end
    check("wd accepted", acc >= 0, 1'b1);
    check("wd rise offset from accept", rise - acc, 18);
    repeat (5) @(negedge clk);
    check("wd sticky while hung", {timeout, busy, d_done}, 3'b110);
    mem_hang = 1'b0;
    dn = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (d_done) begin dn++; d_valid = 1'b0; end
    end
    d_valid = 1'b0;
    check("wd done after release", dn, 1);
    check("wd rdata", d_rdata, 32'h0BAD_F00D);
    check("wd still sticky", timeout, 1'b1);

    // Reset while waiting for the controller.
    mem_lat = 8; mem_data = 32'h1111_2222;
    @(negedge clk);
    if_addr = 32'h300; if_valid = 1'b1;
    acc = -1;
    for (int t = 0; t < 20 && acc < 0; t++) begin
      @(negedge clk);
      if (mif.m_req_valid) acc = t;
    end
    repeat (4) @(negedge clk);
    check("midrst in wait", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst busy/valid/timeout", {busy, mif.m_req_valid, timeout}, 3'b000);
    check("midrst outputs", {if_rdata, d_rdata, mif.m_addr}, 96'h0);
    if_valid = 1'b0;
    dn = 0;
    repeat (3) begin @(negedge clk); dn += int'(if_done | d_done); end
    rst_n = 1'b1;
    repeat (10) begin @(negedge clk); dn += int'(if_done | d_done); end
    check("midrst no done", dn, 0);
    run_vec(vecs[0], "post-reset fetch");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
